// File: rtl/route_pkg.sv
// rtl/route_pkg.sv - shared constants, FSM states and table entry type for the pin router
package route_pkg;

  localparam int NPINS  = 29;
  localparam int NPORTS = 2;
  localparam int IDXW   = 5;
  localparam int PW     = 1;

  typedef enum logic [1:0] {IDLE, SCAN, APPLY, REPORT} state_t;

  typedef struct packed {
    logic            en;
    logic [IDXW-1:0] pin;
  } route_entry_t;

endpackage

// File: rtl/route_scan_chk.sv
// rtl/route_scan_chk.sv - checks one staging entry against the used-pin bitmap
module route_scan_chk
  import route_pkg::*;
(
  input  route_entry_t     entry_i,
  input  logic [NPINS-1:0] bitmap_i,
  output logic             viol_o,
  output logic [NPINS-1:0] bitmap_o
);

  logic [NPINS-1:0] pin_onehot;
  logic             out_of_range;

  // Out-of-range pins decode to an empty one-hot, so they never touch the bitmap.
  always_comb begin
    pin_onehot = '0;
    for (int i = 0; i < NPINS; i++) begin
      pin_onehot[i] = (int'(entry_i.pin) == i);
    end
  end

  assign out_of_range = (int'(entry_i.pin) >= NPINS);
  assign viol_o       = entry_i.en && (out_of_range || (|(pin_onehot & bitmap_i)));
  assign bitmap_o     = entry_i.en ? (bitmap_i | pin_onehot) : bitmap_i;

endmodule

// File: rtl/pin_route_ctrl.sv
// rtl/pin_route_ctrl.sv - staging/active pin routing tables with validated atomic commit
module pin_route_ctrl
  import route_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [PW-1:0]          wr_port,
  input  logic [IDXW-1:0]        wr_pin,
  input  logic                   wr_en,
  input  logic                   commit,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [PW-1:0]          err_port,
  output logic [NPORTS-1:0]      route_en,
  output logic [NPORTS*IDXW-1:0] route_sel
);

  state_t           state_q, state_d;
  logic [PW-1:0]    idx_q, idx_d;
  logic [NPINS-1:0] bitmap_q, bitmap_d;
  logic             err_q, err_d;
  logic [PW-1:0]    err_port_q, err_port_d;
  route_entry_t     stg_q [NPORTS];
  route_entry_t     stg_d [NPORTS];
  route_entry_t     act_q [NPORTS];
  route_entry_t     act_d [NPORTS];

  route_entry_t     scan_entry;
  logic             scan_viol;
  logic [NPINS-1:0] scan_bitmap;

  assign scan_entry = stg_q[idx_q];

  route_scan_chk u_scan_chk (
    .entry_i  (scan_entry),
    .bitmap_i (bitmap_q),
    .viol_o   (scan_viol),
    .bitmap_o (scan_bitmap)
  );

  assign wr_ready = rst_n && (state_q == IDLE);
  assign busy     = (state_q == SCAN) || (state_q == APPLY);
  assign done     = (state_q == REPORT);
  assign err      = err_q;
  assign err_port = err_port_q;

  for (genvar k = 0; k < NPORTS; k++) begin : g_route_out
    assign route_en[k]                 = act_q[k].en;
    assign route_sel[k*IDXW +: IDXW]   = act_q[k].pin;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    bitmap_d   = bitmap_q;
    err_d      = err_q;
    err_port_d = err_port_q;
    stg_d      = stg_q;
    act_d      = act_q;

    // A write sharing the cycle with commit lands before the scan starts reading.
    if (wr_valid && wr_ready && (int'(wr_port) < NPORTS)) begin
      stg_d[wr_port] = '{en: wr_en, pin: wr_pin};
    end

    case (state_q)
      IDLE: begin
        if (commit) begin
          state_d  = SCAN;
          idx_d    = '0;
          bitmap_d = '0;
        end
      end
      SCAN: begin
        if (scan_viol) begin
          err_d      = 1'b1;
          err_port_d = idx_q;
          state_d    = REPORT;
        end else begin
          bitmap_d = scan_bitmap;
          if (idx_q == PW'(NPORTS - 1)) begin
            state_d = APPLY;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      APPLY: begin
        act_d   = stg_q;
        err_d   = 1'b0;
        state_d = REPORT;
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      bitmap_q   <= '0;
      err_q      <= 1'b0;
      err_port_q <= '0;
      for (int k = 0; k < NPORTS; k++) begin
        stg_q[k] <= '0;
        act_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      bitmap_q   <= bitmap_d;
      err_q      <= err_d;
      err_port_q <= err_port_d;
      stg_q      <= stg_d;
      act_q      <= act_d;
    end
  end

endmodule

// File: tb/tb_pin_route_ctrl.sv
// tb/tb_pin_route_ctrl.sv - randomized self-checking bench for pin_route_ctrl
module tb_pin_route_ctrl;

  localparam int NP    = 29;
  localparam int NPORT = 2;
  localparam int IW    = 5;

  logic                  clk = 1'b0;
  logic                  rst_n, wr_valid, wr_ready, wr_en, commit, busy, done, err;
  logic [0:0]            wr_port, err_port;
  logic [IW-1:0]         wr_pin;
  logic [NPORT-1:0]      route_en;
  logic [NPORT*IW-1:0]   route_sel;

  int n_vec = 0;
  int n_bad = 0;

  bit m_stg_en  [NPORT];
  int m_stg_pin [NPORT];
  bit m_act_en  [NPORT];
  int m_act_pin [NPORT];
  bit m_err;
  int m_err_port;

  always #5 clk = ~clk;

  pin_route_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_port   (wr_port),
    .wr_pin    (wr_pin),
    .wr_en     (wr_en),
    .commit    (commit),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_port  (err_port),
    .route_en  (route_en),
    .route_sel (route_sel)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NPORT; k++) begin
      m_stg_en[k] = 0; m_stg_pin[k] = 0; m_act_en[k] = 0; m_act_pin[k] = 0;
    end
    m_err = 0; m_err_port = 0;
  endtask

  task automatic check_active(input string tag);
    logic [NPORT-1:0]    e_en;
    logic [NPORT*IW-1:0] e_sel;
    for (int k = 0; k < NPORT; k++) begin
      e_en[k]           = m_act_en[k];
      e_sel[k*IW +: IW] = m_act_pin[k][IW-1:0];
    end
    chk({tag, "_route_en"}, 32'(route_en), 32'(e_en));
    chk({tag, "_route_sel"}, 32'(route_sel), 32'(e_sel));
  endtask

  task automatic do_write(input int port, input int pin, input bit en);
    chk("wr_ready_idle", 32'(wr_ready), 32'd1);
    wr_valid = 1; wr_port = 1'(port); wr_pin = IW'(pin); wr_en = en;
    tick();
    wr_valid = 0;
    m_stg_en[port] = en; m_stg_pin[port] = pin;
  endtask

  // First enabled entry that is out of range or repeats an earlier enabled pin.
  function automatic int first_bad();
    for (int k = 0; k < NPORT; k++) begin
      if (m_stg_en[k]) begin
        if (m_stg_pin[k] >= NP) return k;
        for (int j = 0; j < k; j++)
          if (m_stg_en[j] && m_stg_pin[j] == m_stg_pin[k]) return k;
      end
    end
    return -1;
  endfunction

  task automatic do_commit(input bit with_wr, input int port, input int pin, input bit en);
    int bad, lat, cyc;
    if (with_wr) begin
      wr_valid = 1; wr_port = 1'(port); wr_pin = IW'(pin); wr_en = en;
      m_stg_en[port] = en; m_stg_pin[port] = pin;
    end
    commit = 1;
    tick();
    commit = 0; wr_valid = 0;
    bad = first_bad();
    lat = (bad < 0) ? NPORT + 2 : bad + 2;
    chk("busy_scan", 32'(busy), 32'd1);
    check_active("scan_hold");
    cyc = 1;
    while (!done && cyc < 16) begin
      tick();
      cyc++;
    end
    chk("done_latency", 32'(cyc), 32'(lat));
    if (bad < 0) begin
      for (int k = 0; k < NPORT; k++) begin
        m_act_en[k] = m_stg_en[k]; m_act_pin[k] = m_stg_pin[k];
      end
      m_err = 0;
    end else begin
      m_err = 1; m_err_port = bad;
    end
    chk("err", 32'(err), 32'(m_err));
    if (m_err) chk("err_port", 32'(err_port), 32'(m_err_port));
    check_active("after_done");
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("ready_after", 32'(wr_ready), 32'd1);
  endtask

  initial begin
    int ndone, cyc, pin;
    bit acc;
    rst_n = 0; wr_valid = 0; wr_port = 0; wr_pin = 0; wr_en = 0; commit = 0;
    model_reset();
    tick(); tick();
    chk("rst_ready", 32'(wr_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_port", 32'(err_port), 32'd0);
    check_active("rst");
    rst_n = 1;
    tick();
    chk("ready_release", 32'(wr_ready), 32'd1);

    do_write(0, 1, 1); do_write(1, 2, 1);
    do_commit(0, 0, 0, 0);
    chk("t1_sel", 32'(route_sel), 32'({5'd2, 5'd1}));
    do_write(0, 3, 1); do_write(1, 3, 1);
    do_commit(0, 0, 0, 0);
    do_write(1, 29, 1);
    do_commit(0, 0, 0, 0);
    do_write(0, 31, 1);
    do_commit(0, 0, 0, 0);

    // Commit re-pulsed during SCAN with a write held until the controller idles.
    do_write(0, 10, 1); do_write(1, 11, 1);
    commit = 1;
    tick();
    cyc = 1; ndone = 0;
    wr_valid = 1; wr_port = 0; wr_pin = 7; wr_en = 1;
    for (int i = 0; i < 12; i++) begin
      if (done) ndone++;
      if (wr_valid) chk("ready_hold", 32'(wr_ready), 32'(cyc > NPORT + 2));
      acc = wr_valid && wr_ready;
      tick();
      cyc++;
      commit = 0;
      if (acc) begin
        wr_valid = 0; m_stg_en[0] = 1; m_stg_pin[0] = 7;
      end
    end
    chk("single_done", 32'(ndone), 32'd1);
    chk("held_wr_taken", 32'(wr_valid), 32'd0);
    m_act_en[0] = 1; m_act_pin[0] = 10; m_act_en[1] = 1; m_act_pin[1] = 11; m_err = 0;
    check_active("t4");
    do_commit(0, 0, 0, 0);

    // Reset in the middle of a scan discards the commit.
    do_write(0, 12, 1); do_write(1, 13, 1);
    commit = 1;
    tick();
    commit = 0;
    tick();
    rst_n = 0;
    tick();
    model_reset();
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(wr_ready), 32'd0);
    check_active("midrst");
    rst_n = 1;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 32'd0);
    chk("midrst_ready_rel", 32'(wr_ready), 32'd1);

    do_write(1, 9, 1);
    do_commit(1, 0, 5, 0);
    chk("t6_en0", 32'(route_en[0]), 32'd0);

    for (int it = 0; it < 40; it++) begin
      int nw;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) begin
        pin = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 4);
        do_write($urandom_range(0, 1), pin, 1'($urandom_range(0, 1)));
      end
      pin = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 4);
      do_commit(($urandom_range(0, 3) == 0), $urandom_range(0, 1), pin, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
